// File: rtl/ppm_frame_scheduler.sv
// PPM frame scheduler: accepts one symbol per frame over valid/ready and places
// a PULSE_CYCLES-wide pulse at the start of the selected slot, followed by guard slots.
module ppm_frame_scheduler #(
    parameter int unsigned SYM_BITS     = 3,
    parameter int unsigned SLOT_CYCLES  = 4,
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned GUARD_SLOTS  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sym_valid,
    input  logic [SYM_BITS-1:0] sym_data,
    output logic                sym_ready,
    output logic                ppm_out,
    output logic                frame_start,
    output logic                busy,
    output logic [7:0]          underrun_cnt
);
    localparam int unsigned M  = 1 << SYM_BITS;
    localparam int unsigned F  = (M + GUARD_SLOTS) * SLOT_CYCLES;
    localparam int unsigned KW = $clog2(F);
    localparam logic [KW-1:0] K_LAST = KW'(F - 1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [SYM_BITS-1:0] sym_q, sym_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ppm_q, ppm_d;
    logic                fs_q, fs_d;
    logic                busy_q, busy_d;
    logic                at_last, accept;
    logic [31:0]         pulse_lo, k_wide;

    always_comb begin
        at_last   = (state_q == FRAME) && (k_q == K_LAST);
        sym_ready = !rst && en && ((state_q == IDLE) || at_last);
        accept    = sym_valid && sym_ready;

        state_d = state_q;
        k_d     = k_q;
        sym_d   = sym_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FRAME;
                    k_d     = '0;
                    sym_d   = sym_data;
                end
            end
            FRAME: begin
                if (at_last) begin
                    k_d = '0;
                    if (accept) begin
                        sym_d = sym_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (at_last && en && !sym_valid && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
        end

        // Outputs are decoded from next-state so the registered versions line up with k.
        pulse_lo = 32'(sym_d) * SLOT_CYCLES;
        k_wide   = 32'(k_d);
        busy_d   = (state_d == FRAME);
        fs_d     = busy_d && (k_d == '0);
        ppm_d    = busy_d && (k_wide >= pulse_lo) && (k_wide < pulse_lo + PULSE_CYCLES);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            sym_q   <= '0;
            cnt_q   <= '0;
            ppm_q   <= 1'b0;
            fs_q    <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            sym_q   <= sym_d;
            cnt_q   <= cnt_d;
            ppm_q   <= ppm_d;
            fs_q    <= fs_d;
            busy_q  <= busy_d;
        end
    end

    assign ppm_out      = ppm_q;
    assign frame_start  = fs_q;
    assign busy         = busy_q;
    assign underrun_cnt = cnt_q;
endmodule

// File: tb/tb_ppm_frame_scheduler.sv
// Bench for ppm_frame_scheduler: frame-timeline model checked every cycle plus
// directed scenarios with hand-computed pulse/strobe positions.
module tb_ppm_frame_scheduler;
    localparam int F     = 36;
    localparam int SLOT  = 4;
    localparam int PULSE = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic       sym_valid = 1'b1;
    logic [2:0] sym_data = 3'd5;
    logic       sym_ready, ppm_out, frame_start, busy;
    logic [7:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    logic [127:0] fs_v, ppm_v, busy_v, rdy_v;

    ppm_frame_scheduler #(
        .SYM_BITS(3), .SLOT_CYCLES(4), .PULSE_CYCLES(2), .GUARD_SLOTS(1)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .sym_valid(sym_valid), .sym_data(sym_data),
        .sym_ready(sym_ready), .ppm_out(ppm_out), .frame_start(frame_start),
        .busy(busy), .underrun_cnt(underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rng(input int lo, input int hi);
        logic [127:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Timeline model: a frame is identified by the absolute cycle it starts on.
    initial begin
        int cyc = 0;
        int origin = -1000;
        int msym = 0;
        int mcnt = 0;
        int k;
        bit act, e_busy, e_fs, e_ppm, e_rdy;
        forever begin
            @(negedge clk);
            k = cyc - origin;
            act = (k >= 0) && (k < F);
            if (rst) begin
                origin = -1000;
                mcnt = 0;
                act = 0;
                e_busy = 0; e_fs = 0; e_ppm = 0; e_rdy = 0;
            end else begin
                e_busy = act;
                e_fs   = act && (k == 0);
                e_ppm  = act && (k >= msym * SLOT) && (k < msym * SLOT + PULSE);
                e_rdy  = en && (!act || (k == F - 1));
            end
            check("model_busy", 128'(busy), 128'(e_busy));
            check("model_frame_start", 128'(frame_start), 128'(e_fs));
            check("model_ppm_out", 128'(ppm_out), 128'(e_ppm));
            check("model_sym_ready", 128'(sym_ready), 128'(e_rdy));
            check("model_underrun_cnt", 128'(underrun_cnt), 128'(mcnt));
            if (!rst) begin
                if (act && (k == F - 1) && en && !sym_valid && (mcnt < 255)) mcnt++;
                if (e_rdy && sym_valid) begin
                    origin = cyc + 1;
                    msym = int'(sym_data);
                end
            end
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a symbol and returns #1 into frame cycle 0 after the accept edge.
    task automatic send_sym(input int s, input bit keep);
        sym_data  = 3'(s);
        sym_valid = 1'b1;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (sym_ready) begin
                tick();
                if (!keep) sym_valid = 1'b0;
                return;
            end
            tick();
        end
        checks++;
        errors++;
        $display("FAIL send_sym_timeout: got no accept expected accept within 100 cycles");
    endtask

    task automatic observe(input int n, input int vdrop, input int endrop);
        fs_v = '0; ppm_v = '0; busy_v = '0; rdy_v = '0;
        for (int i = 0; i < n; i++) begin
            if (i == vdrop) sym_valid = 1'b0;
            if (i == endrop) en = 1'b0;
            @(negedge clk);
            fs_v[i]   = frame_start;
            ppm_v[i]  = ppm_out;
            busy_v[i] = busy;
            rdy_v[i]  = sym_ready;
            tick();
        end
    endtask

    initial begin
        // 1: reset with valid high, then enable gating of sym_ready
        repeat (3) tick();
        check("rst_outputs", {123'd0, sym_ready, ppm_out, frame_start, busy, 1'b0}, '0);
        check("rst_cnt", 128'(underrun_cnt), 128'd0);
        en = 1'b0;
        rst = 1'b0;
        #1;
        check("en0_ready", 128'(sym_ready), 128'd0);
        tick(); tick();
        check("en0_no_accept", 128'(busy), 128'd0);
        sym_valid = 1'b0;
        en = 1'b1;
        #1;
        check("en1_ready_same_cycle", 128'(sym_ready), 128'd1);
        tick();

        // 2: single symbol 5
        send_sym(5, 0);
        observe(40, -1, -1);
        check("t2_fs", fs_v, rng(0, 0));
        check("t2_ppm", ppm_v, rng(20, 21));
        check("t2_busy", busy_v, rng(0, 35));
        check("t2_ready", rdy_v, rng(35, 39));
        check("t2_underrun", 128'(underrun_cnt), 128'd1);

        // 3: back-to-back 7 then 0; data changes right after accept
        send_sym(7, 1);
        sym_data = 3'd0;
        observe(76, 36, -1);
        check("t3_fs", fs_v, rng(0, 0) | rng(36, 36));
        check("t3_ppm", ppm_v, rng(28, 29) | rng(36, 37));
        check("t3_busy", busy_v, rng(0, 71));
        check("t3_ready", rdy_v, rng(35, 35) | rng(71, 75));
        check("t3_underrun", 128'(underrun_cnt), 128'd2);

        // 4: en dropped at k=10 of a symbol-3 frame, valid kept high
        send_sym(3, 1);
        observe(40, -1, 10);
        check("t4_fs", fs_v, rng(0, 0));
        check("t4_ppm", ppm_v, rng(12, 13));
        check("t4_busy", busy_v, rng(0, 35));
        check("t4_ready", rdy_v, '0);
        check("t4_underrun", 128'(underrun_cnt), 128'd2);
        en = 1'b1;
        observe(2, 1, -1);
        check("t4_reaccept_ready", rdy_v & 128'h3, 128'h1);
        check("t4_reaccept_fs", fs_v & 128'h3, 128'h2);
        observe(40, -1, -1);

        // 5: asynchronous reset mid-pulse
        send_sym(5, 0);
        repeat (21) tick();
        #2;
        check("t5_pre_rst_ppm", 128'(ppm_out), 128'd1);
        rst = 1'b1;
        #1;
        check("t5_async_ppm", 128'(ppm_out), 128'd0);
        check("t5_async_busy", 128'(busy), 128'd0);
        check("t5_async_cnt", 128'(underrun_cnt), 128'd0);
        tick();
        rst = 1'b0;
        send_sym(2, 0);
        observe(40, -1, -1);
        check("t5_ppm", ppm_v, rng(8, 9));
        check("t5_fs", fs_v, rng(0, 0));

        // 6: saturation over 300 isolated frames
        for (int n = 0; n < 300; n++) begin
            send_sym(n % 8, 0);
            repeat (F) tick();
        end
        tick();
        check("t6_saturated", 128'(underrun_cnt), 128'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
